// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding, parity modes, sizing helpers.
// Pure declarations; no logic, no latency, no flow control.
package uart_rx_param_pkg;

   typedef logic [2:0] uart_rx_state_t;

   localparam uart_rx_state_t S_IDLE   = 3'd0;
   localparam uart_rx_state_t S_START  = 3'd1;
   localparam uart_rx_state_t S_DATA   = 3'd2;
   localparam uart_rx_state_t S_PARITY = 3'd3;
   localparam uart_rx_state_t S_STOP   = 3'd4;

   typedef logic parity_mode_t;
   localparam parity_mode_t PAR_EVEN = 1'b0;
   localparam parity_mode_t PAR_ODD  = 1'b1;

   function automatic int half_bit(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

   // FIFO entry is {data, frame_err, parity_err}
   function automatic int entry_w(input int data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Host-side bundle of the UART receiver: serial input, ack pulse, head-of-FIFO data and status.
// slave = receiver side, master = host/pin driver side.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 RXD;
   logic                 DATA_ACK;
   logic [DATA_BITS-1:0] DATA;
   logic                 RX_BUSY;
   logic                 RX_READY;
   logic                 RX_ERROR;
   logic                 FRAME_ERR;
   logic                 PARITY_ERR;
   logic                 OVERRUN;

   modport slave (
      input  RXD, DATA_ACK,
      output DATA, RX_BUSY, RX_READY, RX_ERROR, FRAME_ERR, PARITY_ERR, OVERRUN
   );

   modport master (
      output RXD, DATA_ACK,
      input  DATA, RX_BUSY, RX_READY, RX_ERROR, FRAME_ERR, PARITY_ERR, OVERRUN
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO; head is combinational (zero when empty), push lands one edge later.
// Pop on empty is ignored; push on full is refused unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W:0]   r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_full     = (r_count == FULL_CNT);
   assign o_empty    = (r_count == '0);
   assign w_pop_ok   = i_pop & ~o_empty;
   assign w_push_ok  = i_push & (~o_full | w_pop_ok);
   assign o_head_dat = o_empty ? '0 : r_mem[r_rd];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + 1'b1;
         if (w_pop_ok)  r_rd <= r_rd + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push_ok) r_mem[r_wr] <= i_push_dat;
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop RXD synchroniser, mid-bit sampling FSM, FIFO of {data, ferr, perr}.
// Entry pushed on the edge after the last stop sample; a full FIFO drops the frame and sets sticky OVERRUN.
module uart_rx_param
   import uart_rx_param_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic          CLK,
   input  logic          RST,
   uart_rx_param_if.slave bus
);
   localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
   localparam int ENTRY_W  = entry_w(DATA_BITS);
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int BIT_W    = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_M1    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_M1   = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_M1   = BIT_W'(STOP_BITS - 1);
   localparam parity_mode_t     PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   logic [1:0]           r_sync;
   uart_rx_state_t       r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [BIT_W-1:0]     r_bits;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_ferr;
   logic                 r_perr;
   logic                 r_overrun;

   logic                 w_rxs;
   logic                 w_tick;
   logic                 w_ferr_now;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_drop;
   logic                 w_full;
   logic                 w_empty;
   logic [ENTRY_W-1:0]   w_head;

   assign w_rxs      = r_sync[1];
   // START counts to mid-bit; every later state counts whole bit periods
   assign w_tick     = (r_state == S_START) ? (r_cnt == HALF_M1) : (r_cnt == BIT_M1);
   assign w_ferr_now = r_ferr | ~w_rxs;
   assign w_push     = (r_state == S_STOP) & w_tick & (r_bits == STOP_M1);
   assign w_pop      = bus.DATA_ACK & ~w_empty;
   assign w_drop     = w_push & w_full & ~w_pop;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync    <= 2'b11;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bits    <= '0;
         r_shift   <= '0;
         r_ferr    <= 1'b0;
         r_perr    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], bus.RXD};

         if (r_state == S_IDLE || w_tick) r_cnt <= '0;
         else                             r_cnt <= r_cnt + 1'b1;

         case (r_state)
            S_IDLE: begin
               if (!w_rxs) begin
                  r_state <= S_START;
                  r_bits  <= '0;
                  r_ferr  <= 1'b0;
                  r_perr  <= 1'b0;
               end
            end
            S_START: begin
               if (w_tick) r_state <= w_rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (w_tick) begin
                  r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                  if (r_bits == DATA_M1) begin
                     r_bits  <= '0;
                     r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     r_bits <= r_bits + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (w_tick) begin
                  r_perr  <= (^r_shift ^ w_rxs) != PAR_SENSE;
                  r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_ferr <= w_ferr_now;
                  if (r_bits == STOP_M1) r_state <= S_IDLE;
                  else                   r_bits  <= r_bits + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_drop)     r_overrun <= 1'b1;
         else if (w_pop) r_overrun <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK        (CLK),
      .RST        (RST),
      .i_push     (w_push),
      .i_push_dat ({r_shift, w_ferr_now, r_perr}),
      .i_pop      (bus.DATA_ACK),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign bus.DATA       = w_head[ENTRY_W-1:2];
   assign bus.FRAME_ERR  = w_head[1];
   assign bus.PARITY_ERR = w_head[0];
   assign bus.RX_READY   = ~w_empty;
   assign bus.RX_BUSY    = (r_state != S_IDLE);
   assign bus.OVERRUN    = r_overrun;
   assign bus.RX_ERROR   = w_head[1] | w_head[0] | r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default 8N1 instance (A) and an 8E2, 6-clk/bit, 2-deep instance (B).
// Table-driven frames, hand-written corner sequences, and random frames against a queue model on B.
module tb_uart_rx_param;
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   uart_rx_param_if #(.DATA_BITS(8)) ifa ();
   uart_rx_param_if #(.DATA_BITS(8)) ifb ();

   uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));

   uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(6), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(2))
      dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic [7:0] exp_d;
      logic       exp_ferr;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       ferr;
      logic       perr;
   } ent_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
      return {6'h3F, stop, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_b(input logic [7:0] d, input logic par,
                                          input logic s1, input logic s2);
      return {4'hF, s2, s1, par, d, 1'b0};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic ack(input int which);
      if (which == 0) ifa.DATA_ACK = 1'b1; else ifb.DATA_ACK = 1'b1;
      @(negedge CLK);
      ifa.DATA_ACK = 1'b0;
      ifb.DATA_ACK = 1'b0;
   endtask

   // Drives bits LSB first, cpb cycles each; busy_fall = loop index whose next edge dropped RX_BUSY.
   task automatic send(input int which, input logic [15:0] bits, input int nbits, input int cpb,
                       input int ack_at, output int busy_fall);
      logic seen;
      logic busy;
      seen      = 1'b0;
      busy_fall = -1;
      for (int c = 0; c < nbits * cpb; c++) begin
         if (which == 0) begin
            ifa.RXD      = bits[c / cpb];
            ifa.DATA_ACK = (c == ack_at);
         end else begin
            ifb.RXD      = bits[c / cpb];
            ifb.DATA_ACK = (c == ack_at);
         end
         @(negedge CLK);
         busy = (which == 0) ? ifa.RX_BUSY : ifb.RX_BUSY;
         if (busy) seen = 1'b1;
         else if (seen && busy_fall < 0) busy_fall = c;
      end
      ifa.DATA_ACK = 1'b0;
      ifb.DATA_ACK = 1'b0;
      if (which == 0) ifa.RXD = 1'b1; else ifb.RXD = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       vecs[5];
      ent_t       q[$];
      ent_t       e;
      logic       m_ovr;
      logic [7:0] d;
      logic       par, s1, s2;
      int         bf, lat, k, nacks;
      logic       found;

      vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
      vecs[1] = '{8'hD5, 1'b0, 8'hD5, 1'b1};
      vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
      vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0};

      ifa.RXD = 1'b1; ifa.DATA_ACK = 1'b0;
      ifb.RXD = 1'b1; ifb.DATA_ACK = 1'b0;
      RST = 1'b1;
      idle(3);
      check("rst_a_data",  ifa.DATA, 0);
      check("rst_a_busy",  ifa.RX_BUSY, 0);
      check("rst_a_ready", ifa.RX_READY, 0);
      check("rst_a_error", ifa.RX_ERROR, 0);
      check("rst_a_ovr",   ifa.OVERRUN, 0);
      check("rst_b_ready", ifb.RX_READY, 0);
      check("rst_b_perr",  ifb.PARITY_ERR, 0);
      RST = 1'b0;
      idle(5);

      // Table of single frames on A, each acked afterwards
      lat = -1;
      for (int i = 0; i < 5; i++) begin
         send(0, frame_a(vecs[i].d, vecs[i].stop), 10, 8, -1, bf);
         check($sformatf("v%0d_push_window", i), (bf + 1 >= 71) && (bf + 1 <= 79), 1);
         if (i == 0) lat = bf;
         idle(8);
         check($sformatf("v%0d_data", i),  ifa.DATA, vecs[i].exp_d);
         check($sformatf("v%0d_ferr", i),  ifa.FRAME_ERR, vecs[i].exp_ferr);
         check($sformatf("v%0d_perr", i),  ifa.PARITY_ERR, 0);
         check($sformatf("v%0d_err", i),   ifa.RX_ERROR, vecs[i].exp_ferr);
         check($sformatf("v%0d_ready", i), ifa.RX_READY, 1);
         check($sformatf("v%0d_busy", i),  ifa.RX_BUSY, 0);
         ack(0);
         check($sformatf("v%0d_ack_ready", i), ifa.RX_READY, 0);
         check($sformatf("v%0d_ack_data", i),  ifa.DATA, 0);
         check($sformatf("v%0d_ack_ferr", i),  ifa.FRAME_ERR, 0);
      end

      // Glitch: two cycles low must not produce a frame
      ifa.RXD = 1'b0;
      idle(2);
      ifa.RXD = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge CLK);
         if (ifa.RX_BUSY) found = 1'b1;
      end
      check("glitch_busy_pulse", found, 1);
      idle(12);
      check("glitch_busy_end", ifa.RX_BUSY, 0);
      check("glitch_no_push", ifa.RX_READY, 0);

      // Overrun: five frames into a 4-deep FIFO with no acks
      for (int i = 1; i <= 5; i++) begin
         send(0, frame_a(8'(i), 1'b1), 10, 8, -1, bf);
         idle(4);
         if (i == 4) check("ovr_not_yet", ifa.OVERRUN, 0);
      end
      check("ovr_set", ifa.OVERRUN, 1);
      check("ovr_error", ifa.RX_ERROR, 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovr_head%0d", i), ifa.DATA, i);
         ack(0);
         check($sformatf("ovr_clear%0d", i), ifa.OVERRUN, 0);
      end
      check("ovr_drained", ifa.RX_READY, 0);

      // Ack in the push cycle of a frame arriving at a full FIFO
      send(0, frame_a(8'h11, 1'b1), 10, 8, -1, bf); idle(4);
      send(0, frame_a(8'h22, 1'b1), 10, 8, -1, bf); idle(4);
      send(0, frame_a(8'h33, 1'b1), 10, 8, -1, bf); idle(4);
      send(0, frame_a(8'h44, 1'b1), 10, 8, -1, bf); idle(4);
      send(0, frame_a(8'h55, 1'b1), 10, 8, bf, k);
      idle(6);
      check("pushpop_full_ovr", ifa.OVERRUN, 0);
      for (int i = 2; i <= 5; i++) begin
         check($sformatf("pushpop_head%0d", i), ifa.DATA, 8'h11 * i);
         ack(0);
      end
      check("pushpop_four_entries", ifa.RX_READY, 0);

      // Ack in the push cycle with an empty FIFO: ack ignored, push kept
      send(0, frame_a(8'h3C, 1'b1), 10, 8, lat, bf);
      idle(6);
      check("pushpop_empty_ready", ifa.RX_READY, 1);
      check("pushpop_empty_data", ifa.DATA, 8'h3C);
      ack(0);
      ack(0);
      check("ack_empty_ignored", ifa.RX_READY, 0);
      check("ack_empty_ovr", ifa.OVERRUN, 0);

      // Break: RXD held low completes a framing-error frame and re-enters START
      ifa.RXD = 1'b0;
      idle(100);
      check("break_ready", ifa.RX_READY, 1);
      check("break_data", ifa.DATA, 0);
      check("break_ferr", ifa.FRAME_ERR, 1);
      check("break_busy", ifa.RX_BUSY, 1);
      ifa.RXD = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge CLK);
         if (!ifa.RX_BUSY) found = 1'b1;
      end
      check("break_no_hang", found, 1);
      k = 0;
      while (ifa.RX_READY && k < 8) begin
         ack(0);
         k++;
      end
      check("break_flushed", ifa.RX_READY, 0);
      idle(10);

      // Reset in the middle of a data bit
      send(0, frame_a(8'h77, 1'b1), 10, 8, -1, bf);
      idle(4);
      ifa.RXD = 1'b0;
      idle(28);
      check("mid_busy_pre", ifa.RX_BUSY, 1);
      RST = 1'b1;
      #1;
      check("mid_rst_data",  ifa.DATA, 0);
      check("mid_rst_ready", ifa.RX_READY, 0);
      check("mid_rst_busy",  ifa.RX_BUSY, 0);
      check("mid_rst_error", ifa.RX_ERROR, 0);
      ifa.RXD = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      idle(20);
      check("mid_rst_no_push", ifa.RX_READY, 0);
      send(0, frame_a(8'hA5, 1'b1), 10, 8, -1, bf);
      idle(6);
      check("post_rst_data",  ifa.DATA, 8'hA5);
      check("post_rst_error", ifa.RX_ERROR, 0);
      ack(0);

      // Even parity on B: good then bad parity bit
      send(1, frame_b(8'h03, 1'b0, 1'b1, 1'b1), 12, 6, -1, bf); idle(6);
      send(1, frame_b(8'h03, 1'b1, 1'b1, 1'b1), 12, 6, -1, bf); idle(6);
      check("par_first_data", ifb.DATA, 8'h03);
      check("par_first_perr", ifb.PARITY_ERR, 0);
      ack(1);
      check("par_second_data", ifb.DATA, 8'h03);
      check("par_second_perr", ifb.PARITY_ERR, 1);
      check("par_second_err",  ifb.RX_ERROR, 1);
      ack(1);
      check("par_drained", ifb.RX_READY, 0);

      // Random frames on B against a queue model of a 2-deep FIFO
      m_ovr = 1'b0;
      for (int n = 0; n < 24; n++) begin
         d   = 8'($urandom);
         par = ^d;
         if ($urandom_range(0, 3) == 0) par = ~par;
         s1  = ($urandom_range(0, 5) != 0);
         s2  = ($urandom_range(0, 5) != 0);
         send(1, frame_b(d, par, s1, s2), 12, 6, -1, bf);
         idle(10);
         e.d    = d;
         e.ferr = !(s1 && s2);
         e.perr = (^d) ^ par;
         if (q.size() < 2) q.push_back(e);
         else m_ovr = 1'b1;
         check($sformatf("rnd%0d_ready", n), ifb.RX_READY, q.size() != 0);
         check($sformatf("rnd%0d_ovr", n), ifb.OVERRUN, m_ovr);
         nacks = $urandom_range(0, 2);
         for (int a = 0; a < nacks; a++) begin
            if (q.size() != 0) begin
               check($sformatf("rnd%0d_data", n), ifb.DATA, q[0].d);
               check($sformatf("rnd%0d_ferr", n), ifb.FRAME_ERR, q[0].ferr);
               check($sformatf("rnd%0d_perr", n), ifb.PARITY_ERR, q[0].perr);
               check($sformatf("rnd%0d_err", n), ifb.RX_ERROR, q[0].ferr | q[0].perr | m_ovr);
               e = q.pop_front();
               m_ovr = 1'b0;
            end
            ack(1);
         end
         check($sformatf("rnd%0d_post_ready", n), ifb.RX_READY, q.size() != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
